// File: rtl/button_debouncer_if.sv
// Button bus between the raw push-button pins and the debouncer.
// The master drives the raw inputs; the slave returns the debounced level and the press pulse.
interface button_debouncer_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  modport master (output btn_in, input btn_level, input btn_pulse);
  modport slave  (input btn_in, output btn_level, output btn_pulse);
endinterface

// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: 2-FF synchroniser, stability counter, debounced level, press pulse.
// Optional auto-repeat of the press pulse while held is enabled with `define DEBOUNCER_REPEAT_EN.
module button_debouncer #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  button_debouncer_if.slave  bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_debouncer: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_pulse;
  logic [CW-1:0]    r_cnt     [N_BTN];
  logic [CW-1:0]    w_cnt_nxt [N_BTN];
  logic [N_BTN-1:0] w_level_nxt;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_rpt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.btn_in;
      r_s2 <= r_s1;
    end
  end

  // Any cycle where s2 agrees with the level wipes the count, so bounces earn no partial credit.
  always_comb begin
    w_level_nxt = r_level;
    for (int i = 0; i < N_BTN; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_LAST) w_level_nxt[i] = r_s2[i];
        else                      w_cnt_nxt[i]   = r_cnt[i] + CW'(1);
      end
    end
  end

  assign w_rise = w_level_nxt & ~r_level;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_level <= '0;
      r_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_pulse <= w_rise | w_rpt;
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

`ifdef DEBOUNCER_REPEAT_EN
  localparam int            RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW       = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]    r_rpt [N_BTN];
  logic [N_BTN-1:0] r_rph;

  // r_rph selects the first (delay) interval versus the steady repeat period; a falling level wins.
  always_comb begin
    w_rpt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_rpt[i] = r_level[i] & w_level_nxt[i] &
                 (r_rpt[i] == (r_rph[i] ? PER_LAST : DLY_LAST));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rph <= '0;
      for (int i = 0; i < N_BTN; i++) r_rpt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!r_level[i]) begin
          r_rpt[i] <= '0;
          r_rph[i] <= 1'b0;
        end else if (w_rpt[i]) begin
          r_rpt[i] <= '0;
          r_rph[i] <= 1'b1;
        end else begin
          r_rpt[i] <= r_rpt[i] + RW'(1);
        end
      end
    end
  end
`else
  assign w_rpt = '0;
`endif

  assign bus.btn_level = r_level;
  assign bus.btn_pulse = r_pulse;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: per-edge vector table plus hand sequences for reset and auto-repeat.
// Entry j of the table is checked just after edge j and its btn value is launched right after that edge.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic clr_n;

  button_debouncer_if #(.N_BTN(3)) bus();

  button_debouncer #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;
    logic [2:0] lvl;
    logic [2:0] pls;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

`ifdef DEBOUNCER_REPEAT_EN
  localparam logic [2:0] T1_RPT = 3'b001;
  localparam int         N_EXP  = 4;
  localparam int         EXP_EDGES [4] = '{6, 22, 30, 38};
`else
  localparam logic [2:0] T1_RPT = 3'b000;
  localparam int         N_EXP  = 1;
  localparam int         EXP_EDGES [4] = '{6, 0, 0, 0};
`endif

  task automatic check(input string name, input int idx, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%b want=%b", name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  function automatic void add(input logic [2:0] b, input logic [2:0] l, input logic [2:0] p, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{btn: b, lvl: l, pls: p});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulse_edges[$];
  int side_hits;

  initial begin
    // T1: clean press on ch0, 20 cycles
    add(3'b001, 3'b000, 3'b000, 6);
    add(3'b001, 3'b001, 3'b001, 1);
    add(3'b001, 3'b001, 3'b000, 13);
    add(3'b000, 3'b001, 3'b000, 2);
    add(3'b000, 3'b001, T1_RPT, 1);
    add(3'b000, 3'b001, 3'b000, 3);
    add(3'b000, 3'b000, 3'b000, 4);
    // T2: ch1 bounces for 10 cycles, then stays high
    for (int k = 0; k < 10; k++) add((k % 2 == 0) ? 3'b010 : 3'b000, 3'b000, 3'b000, 1);
    add(3'b010, 3'b000, 3'b000, 6);
    add(3'b010, 3'b010, 3'b010, 1);
    add(3'b010, 3'b010, 3'b000, 3);
    add(3'b000, 3'b010, 3'b000, 6);
    add(3'b000, 3'b000, 3'b000, 4);
    // T3: 3-cycle glitch on ch2 never qualifies
    add(3'b100, 3'b000, 3'b000, 3);
    add(3'b000, 3'b000, 3'b000, 7);
    // Shortest qualifying press: exactly 4 cycles on ch0
    add(3'b001, 3'b000, 3'b000, 4);
    add(3'b000, 3'b000, 3'b000, 2);
    add(3'b000, 3'b001, 3'b001, 1);
    add(3'b000, 3'b001, 3'b000, 3);
    add(3'b000, 3'b000, 3'b000, 4);
    // T4: all three together
    add(3'b111, 3'b000, 3'b000, 6);
    add(3'b111, 3'b111, 3'b111, 1);
    add(3'b111, 3'b111, 3'b000, 3);
    add(3'b000, 3'b111, 3'b000, 6);
    add(3'b000, 3'b000, 3'b000, 4);
    // Staggered presses stay independent
    add(3'b001, 3'b000, 3'b000, 2);
    add(3'b011, 3'b000, 3'b000, 4);
    add(3'b011, 3'b001, 3'b001, 1);
    add(3'b011, 3'b001, 3'b000, 1);
    add(3'b011, 3'b011, 3'b010, 1);
    add(3'b011, 3'b011, 3'b000, 3);
    add(3'b000, 3'b011, 3'b000, 6);
    add(3'b000, 3'b000, 3'b000, 4);

    // Reset state
    clr_n      = 1'b1;
    bus.btn_in = 3'b000;
    #1 clr_n = 1'b0;
    repeat (3) tick();
    check("rst_level", 0, bus.btn_level, 3'b000);
    check("rst_pulse", 0, bus.btn_pulse, 3'b000);
    clr_n = 1'b1;
    repeat (3) tick();

    // Table-driven vectors
    tick();
    for (int j = 0; j < tbl.size(); j++) begin
      check("tbl_level", j, bus.btn_level, tbl[j].lvl);
      check("tbl_pulse", j, bus.btn_pulse, tbl[j].pls);
      bus.btn_in = tbl[j].btn;
      tick();
    end
    repeat (4) tick();

    // T5: reset while held, release, then the held button counts as a new press
    bus.btn_in = 3'b001;
    repeat (9) tick();
    check("t5_pre_level", 9, bus.btn_level, 3'b001);
    clr_n = 1'b0;
    #1;
    check("t5_async_level", 9, bus.btn_level, 3'b000);
    for (int e = 10; e <= 14; e++) begin
      tick();
      check("t5_rst_level", e, bus.btn_level, 3'b000);
      check("t5_rst_pulse", e, bus.btn_pulse, 3'b000);
    end
    clr_n = 1'b1;
    for (int e = 15; e <= 21; e++) begin
      tick();
      check("t5_level", e, bus.btn_level, (e >= 20) ? 3'b001 : 3'b000);
      check("t5_pulse", e, bus.btn_pulse, (e == 20) ? 3'b001 : 3'b000);
    end
    bus.btn_in = 3'b000;
    repeat (8) tick();
    check("t5_idle_level", 0, bus.btn_level, 3'b000);

    // T6: ch0 held 40 cycles; collect pulse edges
    side_hits = 0;
    tick();
    bus.btn_in = 3'b001;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (bus.btn_pulse[0] === 1'b1) pulse_edges.push_back(e);
      if (bus.btn_pulse[2:1] !== 2'b00) side_hits++;
      if (e == 45) check("t6_level_held", e, bus.btn_level, 3'b001);
      if (e == 46) check("t6_level_fall", e, bus.btn_level, 3'b000);
      if (e == 40) bus.btn_in = 3'b000;
    end
    check_int("t6_pulse_count", pulse_edges.size(), N_EXP);
    for (int k = 0; k < N_EXP; k++) begin
      check_int("t6_pulse_edge", (k < pulse_edges.size()) ? pulse_edges[k] : -1, EXP_EDGES[k]);
    end
    check_int("t6_side_pulses", side_hits, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
